// File: rtl/addr_unit.sv
// Address-generation stage: program counter, stack pointer and data-address register,
// with the ROM/RAM address outputs and the PC byte drive onto the shared data bus.
module addr_unit #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [7:0]  SP_RESET = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        pch_car,
    input  logic        pcl_car,
    input  logic        sel_data_pc,
    input  logic        pch_bus,
    input  logic        pcl_bus,
    input  logic        dir_car,
    input  logic        sp_car,
    input  logic        sp_incdec,
    input  logic        sel_sp,
    output logic [15:0] rom_addr,
    output logic [7:0]  ram_addr,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        sp_empty,
    output logic        sp_full,
    output logic        stack_err,
    output logic        bus_err
);

    logic [15:0] pc;
    logic [7:0]  sp;
    logic [7:0]  dir;

    logic [15:0] pc_next;
    logic [7:0]  sp_next;
    logic        sp_fault;

    always_comb begin
        pc_next = pc;
        if (pcl_car && !sel_data_pc) begin
            pc_next = pc + 16'd1;
        end else if (sel_data_pc) begin
            if (pch_car) pc_next[15:8] = data_in;
            if (pcl_car) pc_next[7:0]  = data_in;
        end
    end

    // An out-of-range push/pop leaves SP where it is and only raises the sticky flag.
    always_comb begin
        sp_next  = sp;
        sp_fault = 1'b0;
        if (sp_car) begin
            if (sp_incdec) begin
                if (sp == 8'hFF) sp_fault = 1'b1;
                else             sp_next  = sp + 8'd1;
            end else begin
                if (sp == 8'h00) sp_fault = 1'b1;
                else             sp_next  = sp - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= PC_RESET;
            sp        <= SP_RESET;
            dir       <= 8'h00;
            stack_err <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            pc <= pc_next;
            sp <= sp_next;
            if (dir_car) dir <= data_in;
            if (sp_fault) stack_err <= 1'b1;
            bus_err <= pch_bus & pcl_bus;
        end
    end

    assign rom_addr = pc;
    assign ram_addr = sel_sp ? sp : dir;
    assign sp_empty = (sp == 8'hFF);
    assign sp_full  = (sp == 8'h00);
    assign data_oe  = pch_bus | pcl_bus;

    // PCL wins when both bus strobes collide; the collision itself is flagged via bus_err.
    always_comb begin
        data_out = 8'h00;
        if (pcl_bus)      data_out = pc[7:0];
        else if (pch_bus) data_out = pc[15:8];
    end

endmodule

// File: tb/tb_addr_unit.sv
// Bench for addr_unit: directed boundary steps followed by random strobes,
// all compared against an arithmetic reference model of PC, SP and DIR.
module tb_addr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        pch_car, pcl_car, sel_data_pc, pch_bus, pcl_bus;
    logic        dir_car, sp_car, sp_incdec, sel_sp;
    logic [15:0] rom_addr;
    logic [7:0]  ram_addr, data_out;
    logic        data_oe, sp_empty, sp_full, stack_err, bus_err;

    always #5 clk = ~clk;

    addr_unit dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .pch_car(pch_car), .pcl_car(pcl_car), .sel_data_pc(sel_data_pc),
        .pch_bus(pch_bus), .pcl_bus(pcl_bus), .dir_car(dir_car),
        .sp_car(sp_car), .sp_incdec(sp_incdec), .sel_sp(sel_sp),
        .rom_addr(rom_addr), .ram_addr(ram_addr), .data_out(data_out),
        .data_oe(data_oe), .sp_empty(sp_empty), .sp_full(sp_full),
        .stack_err(stack_err), .bus_err(bus_err)
    );

    int checks = 0;
    int failures = 0;

    int m_pc, m_sp, m_dir;
    bit m_serr, m_berr;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; data_in = 8'h00; pch_car = 0; pcl_car = 0; sel_data_pc = 0;
        pch_bus = 0; pcl_bus = 0; dir_car = 0; sp_car = 0; sp_incdec = 0; sel_sp = 0;
    endtask

    // Reference model: the PC is a 0..65535 integer, SP a 0..255 integer that saturates.
    task automatic tick();
        bit do_pcl, do_pch, load, inc, pop, push, both;
        int d;
        do_pcl = pcl_car; do_pch = pch_car; load = sel_data_pc; d = data_in;
        pop = sp_car && sp_incdec; push = sp_car && !sp_incdec;
        both = pch_bus && pcl_bus;
        inc = do_pcl && !load;
        @(posedge clk);
        if (rst) begin
            m_pc = 0; m_sp = 255; m_dir = 0; m_serr = 0; m_berr = 0;
        end else begin
            if (inc) m_pc = (m_pc + 1) % 65536;
            else if (load) begin
                if (do_pch) m_pc = d * 256 + (m_pc % 256);
                if (do_pcl) m_pc = (m_pc / 256) * 256 + d;
            end
            if (dir_car) m_dir = d;
            if (push) begin
                if (m_sp == 0) m_serr = 1; else m_sp = m_sp - 1;
            end
            if (pop) begin
                if (m_sp == 255) m_serr = 1; else m_sp = m_sp + 1;
            end
            m_berr = both;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        int exp_out;
        #1;
        exp_out = pcl_bus ? (m_pc % 256) : (pch_bus ? (m_pc / 256) : 0);
        chk({tag, ".rom"},   rom_addr, 16'(m_pc));
        chk({tag, ".ram"},   {8'h00, ram_addr}, 16'(sel_sp ? m_sp : m_dir));
        chk({tag, ".dout"},  {8'h00, data_out}, 16'(exp_out));
        chk({tag, ".oe"},    {15'd0, data_oe}, {15'd0, pch_bus | pcl_bus});
        chk({tag, ".empty"}, {15'd0, sp_empty}, 16'(m_sp == 255));
        chk({tag, ".full"},  {15'd0, sp_full}, 16'(m_sp == 0));
        chk({tag, ".serr"},  {15'd0, stack_err}, {15'd0, m_serr});
        chk({tag, ".berr"},  {15'd0, bus_err}, {15'd0, m_berr});
    endtask

    initial begin
        m_pc = 0; m_sp = 255; m_dir = 0; m_serr = 0; m_berr = 0;

        // Reset with every strobe asserted: reset must win.
        rst = 1; data_in = 8'hA5; pch_car = 1; pcl_car = 1; sel_data_pc = 1;
        pch_bus = 1; pcl_bus = 1; dir_car = 1; sp_car = 1; sp_incdec = 1; sel_sp = 1;
        tick();
        tick();
        idle(); #1;
        chk("rst.rom", rom_addr, 16'h0000);
        chk("rst.dir", {8'h00, ram_addr}, 16'h0000);
        chk("rst.empty", {15'd0, sp_empty}, 16'd1);
        chk("rst.serr", {15'd0, stack_err}, 16'd0);
        chk("rst.berr", {15'd0, bus_err}, 16'd0);
        sel_sp = 1; #1;
        chk("rst.sp", {8'h00, ram_addr}, 16'h00FF);

        // PC byte loads and increments, including the 16-bit wrap.
        idle(); data_in = 8'h12; pch_car = 1; sel_data_pc = 1; tick();
        idle(); data_in = 8'hFF; pcl_car = 1; sel_data_pc = 1; tick();
        idle(); #1; chk("pc.load", rom_addr, 16'h12FF);
        pcl_car = 1; tick();
        idle(); #1; chk("pc.carry", rom_addr, 16'h1300);
        pch_car = 1; sel_data_pc = 0; tick();
        idle(); #1; chk("pc.pch_noload", rom_addr, 16'h1300);
        data_in = 8'hFF; pch_car = 1; pcl_car = 1; sel_data_pc = 1; tick();
        idle(); #1; chk("pc.both", rom_addr, 16'hFFFF);
        pcl_car = 1; tick();
        idle(); #1; chk("pc.wrap", rom_addr, 16'h0000);
        check_model("pc");

        // Stack boundaries.
        idle(); rst = 1; tick();
        idle(); sp_car = 1; sp_incdec = 0; sel_sp = 1;
        for (int i = 0; i < 255; i++) tick();
        idle(); sel_sp = 1; #1;
        chk("stk.bottom", {8'h00, ram_addr}, 16'h0000);
        chk("stk.full", {15'd0, sp_full}, 16'd1);
        chk("stk.noerr", {15'd0, stack_err}, 16'd0);
        sp_car = 1; tick();
        idle(); sel_sp = 1; #1;
        chk("stk.hold", {8'h00, ram_addr}, 16'h0000);
        chk("stk.ovf", {15'd0, stack_err}, 16'd1);
        tick();
        chk("stk.sticky", {15'd0, stack_err}, 16'd1);
        rst = 1; tick();
        idle(); sp_car = 1; sp_incdec = 1; tick();
        idle(); sel_sp = 1; #1;
        chk("stk.udf_hold", {8'h00, ram_addr}, 16'h00FF);
        chk("stk.udf", {15'd0, stack_err}, 16'd1);

        // RAM address mux.
        idle(); rst = 1; tick();
        idle(); data_in = 8'h5A; dir_car = 1; tick();
        idle(); sp_car = 1; tick();
        idle(); #1; chk("mux.dir", {8'h00, ram_addr}, 16'h005A);
        sel_sp = 1; #1; chk("mux.sp", {8'h00, ram_addr}, 16'h00FE);

        // Bus drive and the one-cycle conflict pulse.
        idle(); data_in = 8'hAB; pch_car = 1; sel_data_pc = 1; tick();
        idle(); data_in = 8'hCD; pcl_car = 1; sel_data_pc = 1; tick();
        idle(); pch_bus = 1; #1;
        chk("bus.pch", {8'h00, data_out}, 16'h00AB);
        chk("bus.oe", {15'd0, data_oe}, 16'd1);
        pcl_bus = 1; #1;
        chk("bus.both", {8'h00, data_out}, 16'h00CD);
        tick();
        idle(); #1;
        chk("bus.err", {15'd0, bus_err}, 16'd1);
        chk("bus.idle", {15'd0, data_oe}, 16'd0);
        tick();
        chk("bus.err_clear", {15'd0, bus_err}, 16'd0);

        // Simultaneous PC/SP/DIR updates, then the same strobes under reset.
        idle(); pcl_car = 1; sp_car = 1; dir_car = 1; data_in = 8'h33; tick();
        idle(); #1;
        chk("sim.pc", rom_addr, 16'hABCE);
        chk("sim.dir", {8'h00, ram_addr}, 16'h0033);
        sel_sp = 1; #1; chk("sim.sp", {8'h00, ram_addr}, 16'h00FD);
        pcl_car = 1; sp_car = 1; dir_car = 1; data_in = 8'h77; rst = 1; tick();
        idle(); #1;
        chk("simrst.pc", rom_addr, 16'h0000);
        chk("simrst.dir", {8'h00, ram_addr}, 16'h0000);
        sel_sp = 1; #1; chk("simrst.sp", {8'h00, ram_addr}, 16'h00FF);
        check_model("sim");

        // Random strobes; SP direction is biased in phases so both limits get visited.
        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            data_in     = 8'($urandom);
            pch_car     = 1'($urandom);
            pcl_car     = 1'($urandom);
            sel_data_pc = 1'($urandom);
            pch_bus     = ($urandom_range(0, 3) == 0);
            pcl_bus     = ($urandom_range(0, 3) == 0);
            dir_car     = 1'($urandom);
            sp_car      = ($urandom_range(0, 3) != 0);
            sp_incdec   = ((i / 300) % 2 == 1) ? ($urandom_range(0, 7) != 0)
                                               : ($urandom_range(0, 7) == 0);
            sel_sp      = 1'($urandom);
            check_model("rnd");
            tick();
        end
        idle();
        check_model("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addr_unit.md
Name: addr_unit

Overview:
- Address-generation stage directly downstream of the microprogrammed controller.
- Consumes the controller's PC/SP/DIR control strobes and holds the 16-bit program counter (PCH:PCL), the 8-bit stack pointer and the 8-bit data-address register (DIR).
- Drives the ROM address, the RAM address and the PC bytes onto the shared 8-bit data bus.
- Sits between the controller and the ROM/RAM address pins.

Parameters:
- PC_RESET, 16'h0000, program counter value after reset.
- SP_RESET, 8'hFF, stack pointer value after reset (empty stack).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- data_in  input  8  shared data bus, read side.
- pch_car  input  1  PCHcar strobe: load or update PCH.
- pcl_car  input  1  PCLcar strobe: load or increment PC.
- sel_data_pc  input  1  SelDataPC: 1 = load from data_in, 0 = increment.
- pch_bus  input  1  PCHbus: drive PCH onto the bus.
- pcl_bus  input  1  PCLbus: drive PCL onto the bus.
- dir_car  input  1  DIRcar: load DIR from data_in.
- sp_car  input  1  SPcar: update SP.
- sp_incdec  input  1  SPincdec: 1 = increment (pop), 0 = decrement (push).
- sel_sp  input  1  SelSP: RAM address source, 1 = SP, 0 = DIR.
- rom_addr  output  16  ROM address, equal to the current PC.
- ram_addr  output  8  RAM address.
- data_out  output  8  byte driven to the bus.
- data_oe  output  1  bus drive enable.
- sp_empty  output  1  SP == 8'hFF.
- sp_full  output  1  SP == 8'h00.
- stack_err  output  1  sticky overflow/underflow flag.
- bus_err  output  1  one-cycle conflict pulse.

Behaviour:
- Reset: rst is sampled on the clk edge. On reset: PC=PC_RESET, SP=SP_RESET, DIR=0, stack_err=0, bus_err=0. Reset overrides every strobe in the same cycle.
- Reset mid-sequence: a partial PCH/PCL load is discarded with no residue.
- PC update, evaluated at each edge:
  - pcl_car=1, sel_data_pc=1: PCL <= data_in.
  - pch_car=1, sel_data_pc=1: PCH <= data_in.
  - Both strobes with sel_data_pc=1: both bytes load the same data_in value.
  - pcl_car=1, sel_data_pc=0: PC <= PC+1 at full 16 bits; carry from PCL propagates into PCH; 16'hFFFF wraps to 16'h0000.
  - pch_car=1, sel_data_pc=0: no effect on PCH. If pcl_car is also 1, the increment still applies.
- DIR: dir_car=1 gives DIR <= data_in on the edge.
- SP update, only when sp_car=1:
  - sp_incdec=0 (push): SP <= SP-1. If SP==8'h00 beforehand, SP holds and stack_err <= 1.
  - sp_incdec=1 (pop): SP <= SP+1. If SP==8'hFF beforehand, SP holds and stack_err <= 1.
  - SP never wraps.
  - stack_err is cleared only by rst.
- Combinational outputs (same cycle, no added latency):
  - rom_addr = {PCH,PCL}.
  - ram_addr = sel_sp ? SP : DIR.
  - sp_empty and sp_full decode the current SP.
- Bus drive (combinational):
  - data_oe = pch_bus | pcl_bus.
  - data_out = PCH when only pch_bus is set; PCL when pcl_bus is set; 8'h00 when neither is set.
  - Both set: data_out = PCL, and bus_err is registered high for exactly the next cycle.
- Read-modify timing: a register read on the bus in the same cycle as its own update shows the pre-edge value. New values are visible the cycle after the strobe.
- Latency: every register update completes in one clk cycle from the strobe.
- Independence: all strobes are independent. PC, SP and DIR updates can occur in the same cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with all strobes high -> rom_addr=16'h0000, SP=8'hFF, sp_empty=1, DIR=0, stack_err=0.
- PC load and increment:
  - data_in=8'h12 with pch_car, sel_data_pc=1, then 8'hFF with pcl_car -> rom_addr=16'h12FF.
  - pcl_car, sel_data_pc=0 -> 16'h1300.
  - Load 16'hFFFF then increment -> 16'h0000.
- Stack boundaries:
  - 255 pushes from reset -> SP=8'h00, sp_full=1, stack_err=0.
  - 256th push -> SP stays 8'h00, stack_err=1.
  - Pop from reset -> SP stays 8'hFF, stack_err=1.
- RAM address mux: dir_car with data_in=8'h5A; sp_car push once -> sel_sp=0 gives ram_addr=8'h5A, sel_sp=1 gives 8'hFE.
- Bus drive: PC=16'hABCD; pch_bus -> data_out=8'hAB, data_oe=1; both bus strobes -> data_out=8'hCD and bus_err=1 for one cycle only.
- Simultaneous events: pcl_car increment, sp_car push and dir_car all in one cycle -> all three registers update on that edge. rst asserted on the same edge -> all three registers take reset values.
